// File: rtl/comparador_der_izq.sv
// rtl/comparador_der_izq.sv - bit-serial LSB-first unsigned magnitude comparator (w: A>B, z: A<=B)
// Optional equality output eq enabled by defining COMPARADOR_EQ_EN.
module comparador_der_izq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] wordA,
    input  logic [WIDTH-1:0] wordB,
    output logic             busy,
    output logic             done,
    output logic             w,
`ifdef COMPARADOR_EQ_EN
    output logic             z,
    output logic             eq
`else
    output logic             z
`endif
);

    localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [IDX_W-1:0] idx;
    logic             gt;
    logic             gt_next;
    logic             last_bit;
    logic             accept;
    logic             bit_a;
    logic             bit_b;
`ifdef COMPARADOR_EQ_EN
    logic             diff;
`endif

    assign bit_a = sh_a[0];
    assign bit_b = sh_b[0];

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_bit   = (idx == IDX_W'(WIDTH - 1));
        gt_next    = gt;
        // Later (more significant) bits overwrite the verdict of earlier ones.
        if (bit_a && !bit_b) begin
            gt_next = 1'b1;
        end else if (!bit_a && bit_b) begin
            gt_next = 1'b0;
        end
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = S_SCAN;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_SCAN: begin
                if (last_bit) begin
                    state_next = S_DONE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            w     <= 1'b0;
            z     <= 1'b1;
            sh_a  <= '0;
            sh_b  <= '0;
            idx   <= '0;
            gt    <= 1'b0;
`ifdef COMPARADOR_EQ_EN
            diff  <= 1'b0;
            eq    <= 1'b1;
`endif
        end else begin
            state <= state_next;
            busy  <= (state_next == S_SCAN);
            done  <= (state_next == S_DONE);
            if (accept) begin
                sh_a <= wordA;
                sh_b <= wordB;
                idx  <= '0;
                gt   <= 1'b0;
`ifdef COMPARADOR_EQ_EN
                diff <= 1'b0;
`endif
            end else if (state == S_SCAN) begin
                sh_a <= {1'b0, sh_a[WIDTH-1:1]};
                sh_b <= {1'b0, sh_b[WIDTH-1:1]};
                idx  <= idx + 1'b1;
                gt   <= gt_next;
`ifdef COMPARADOR_EQ_EN
                diff <= diff | (bit_a ^ bit_b);
`endif
                if (last_bit) begin
                    w  <= gt_next;
                    z  <= ~gt_next;
`ifdef COMPARADOR_EQ_EN
                    eq <= ~(diff | (bit_a ^ bit_b));
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_comparador_der_izq.sv
// tb/tb_comparador_der_izq.sv - scoreboard bench for comparador_der_izq
// Optional eq checks follow COMPARADOR_EQ_EN.
module tb_comparador_der_izq;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] wordA;
    logic [WIDTH-1:0] wordB;
    logic             busy;
    logic             done;
    logic             w;
    logic             z;
`ifdef COMPARADOR_EQ_EN
    logic             eq;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic exp_w_q[$];
    logic exp_eq_q[$];
    int   exp_cyc_q[$];

    comparador_der_izq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .wordA (wordA),
        .wordB (wordB),
        .busy  (busy),
        .done  (done),
        .w     (w),
`ifdef COMPARADOR_EQ_EN
        .z     (z),
        .eq    (eq)
`else
        .z     (z)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_w_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                logic ew;
                logic ee;
                int   ec;
                ew = exp_w_q.pop_front();
                ee = exp_eq_q.pop_front();
                ec = exp_cyc_q.pop_front();
                check("w", int'(w), int'(ew));
                check("z", int'(z), int'(!ew));
                check("done_latency", cyc, ec);
                check("busy_in_done", int'(busy), 0);
`ifdef COMPARADOR_EQ_EN
                check("eq", int'(eq), int'(ee));
`endif
            end
        end
    end

    // Drive start at a negedge; the following posedge accepts it.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        start = 1'b1;
        wordA = a;
        wordB = b;
        @(posedge clk);
        #1;
        exp_w_q.push_back(a > b);
        exp_eq_q.push_back(a == b);
        exp_cyc_q.push_back(cyc + WIDTH);
        start = 1'b0;
        wordA = $urandom;
        wordB = $urandom;
        @(negedge clk);
        check("busy_after_accept", int'(busy), 1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 3 * WIDTH) begin
            @(negedge clk);
            n++;
        end
        if (!done) check("done_timeout", 0, 1);
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        reset = 1'b1;
        start = 1'b0;
        wordA = '0;
        wordB = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_w", int'(w), 0);
        check("rst_z", int'(z), 1);
`ifdef COMPARADOR_EQ_EN
        check("rst_eq", int'(eq), 1);
`endif
        reset = 1'b0;
        @(negedge clk);

        issue(8'h00, 8'h00);
        for (int i = 1; i < WIDTH; i++) begin
            check("busy_scan", int'(busy), 1);
            @(negedge clk);
        end
        wait_done();
        @(negedge clk);

        // Back-to-back: new start presented during the DONE cycle.
        issue(8'h06, 8'h01);
        wait_done();
        issue(8'h00, 8'h01);
        wait_done();
        @(negedge clk);

        issue(8'h80, 8'h7F); wait_done(); @(negedge clk);
        issue(8'h01, 8'h02); wait_done(); @(negedge clk);
        issue(8'hE7, 8'h81); wait_done(); @(negedge clk);

        for (int i = 0; i < 20; i++) begin
            check("hold_w", int'(w), 1);
            check("hold_z", int'(z), 0);
            check("hold_done", int'(done), 0);
            @(negedge clk);
        end

        // Start during SCAN must be ignored.
        issue(8'h0A, 8'h09);
        @(negedge clk);
        start = 1'b1;
        wordA = 8'h00;
        wordB = 8'hFF;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (WIDTH + 4) @(negedge clk);

        // Reset mid-scan aborts with no done.
        issue(8'hFF, 8'h00);
        repeat (3) @(negedge clk);
        exp_w_q.delete();
        exp_eq_q.delete();
        exp_cyc_q.delete();
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_w", int'(w), 0);
        check("abort_z", int'(z), 1);
        @(negedge clk);
        reset = 1'b0;
        repeat (WIDTH + 2) @(negedge clk);
        issue(8'h10, 8'h10); wait_done(); @(negedge clk);

        // Randomized traffic with random gaps, including back-to-back.
        for (int i = 0; i < 60; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 0) rb = ra;
            if (i % 7 == 0) rb = ra ^ (8'h01 << $urandom_range(0, WIDTH - 1));
            issue(ra, rb);
            wait_done();
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        repeat (WIDTH + 4) @(negedge clk);
        check("queue_drained", exp_w_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/comparador_der_izq.md
Name: comparador_der_izq

Overview:
- Bit-serial magnitude comparator for two unsigned words, scanning right to left (LSB first, MSB last).
- It is the sequential counterpart of the combinational left-to-right Comparador and produces the same result encoding:
  - w = 1 when A > B.
  - z = 1 when A <= B.
- Used where the operands are compared one bit per clock. It gives a start/busy/done handshake to the control FSM of the datapath.

Parameters:
WIDTH, 8, operand width in bits (>= 2); also the number of scan cycles

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous reset, active-high
start  input  1  request a comparison; sampled in IDLE or DONE only
wordA  input  WIDTH  operand A, unsigned; captured on accepted start
wordB  input  WIDTH  operand B, unsigned; captured on accepted start
busy  output  1  high while scanning
done  output  1  one-cycle pulse; w/z are valid from this cycle onward
w  output  1  1 = A > B (registered, held until the next done)
z  output  1  1 = A <= B (registered, always equal to ~w)

Behaviour:
- Reset (synchronous, reset=1 at an edge):
  - State goes to IDLE.
  - busy=0, done=0, w=0, z=1.
  - Internal shift registers, bit index and gt flag are cleared.
  - Reset mid-scan aborts the comparison; no done is produced.
  - Reset has priority over start.
- States: IDLE, SCAN, DONE.
- IDLE:
  - If start=1 at edge k: capture wordA/wordB into shift registers, set idx=0, gt=0, go to SCAN; busy=1 after edge k.
  - If start=0: stay in IDLE.
- SCAN, one bit per edge (edges k+1 .. k+WIDTH process bits 0 .. WIDTH-1):
  - a=1, b=0: gt <= 1.
  - a=0, b=1: gt <= 0.
  - a==b: gt unchanged.
  - Because the MSB is processed last, the highest differing bit decides the result.
- At edge k+WIDTH (last bit processed):
  - Go to DONE.
  - w <= final gt, z <= ~final gt.
  - done=1 and busy=0 after this edge.
  - Total latency from accepted start to done is WIDTH+1 edges (start sample plus WIDTH scans).
- DONE (lasts one cycle):
  - done=1 for exactly this cycle.
  - If start=1 at the next edge: behave as an IDLE accept (back-to-back operation, no idle gap).
  - Otherwise go to IDLE; done returns to 0.
- start while in SCAN is ignored; the operands already captured are unaffected.
- wordA/wordB changes after the accepting edge have no effect on the comparison in progress.
- w/z change only at the edge that enters DONE. They hold their value through IDLE and the next SCAN.
- Equal operands give gt=0, so w=0 and z=1.
- Outputs are glitch-free registers. There is no combinational path from the inputs to any output.

Optional Feature:
- Macro: COMPARADOR_EQ_EN.
- When defined:
  - Adds output port eq (1 bit, registered).
  - An internal diff flag is cleared on start and set on any bit where a != b.
  - At the edge entering DONE, eq <= ~diff.
  - Reset value of eq is 1.
  - eq is held like w/z, and eq=1 always implies z=1.
- When undefined: no eq port, no diff flag; the rest of the behaviour is identical.

Test Plan:
1. Reset, then start with A=8'h00, B=8'h00 -> busy for 8 cycles, done pulse 9 edges after start; w=0, z=1 (eq=1 when enabled).
2. A=8'h06, B=8'h01 -> w=1, z=0. Then a back-to-back start in the DONE cycle with A=8'h00, B=8'h01 -> next done: w=0, z=1, with no IDLE cycle in between.
3. MSB dominance:
   - A=8'h80, B=8'h7F -> w=1, z=0.
   - A=8'h01, B=8'h02 -> w=0, z=1.
   - A=8'hE7, B=8'h81 -> w=1, z=0.
4. Start with A=8'h0A, B=8'h09. During SCAN, drive start=1 with wordA=8'h00 -> the extra start is ignored; exactly one done; w=1.
5. Start with A=8'hFF, B=8'h00; assert reset at scan cycle 4 -> no done; outputs busy=0, w=0, z=1 on the next edge. A new start with A=8'h10, B=8'h10 -> w=0, z=1.
6. Hold check: after the done for case 3 (w=1), keep start=0 for 20 cycles -> w and z stay unchanged and done stays 0.
